alu_issue_ctrl: RTL and testbench

- Execute-stage sequencer that sits directly upstream of the multi-cycle ALU and feeds it.
- Accepts one decoded operation at a time over a valid/ready issue handshake.
- Drives the ALU enable, control and operands, waits for alu_done, and captures result and flags.
- Owns the architectural HI/LO registers (MULT/DIV/MFHI/MFLO/MTHI/MTLO), presents GPR writebacks over a valid/ready port, and guards against a hung ALU with a timeout.

---
 rtl/alu_issue_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Execute-stage sequencer in front of a multi-cycle ALU. It accepts one
//   decoded operation at a time and drives the ALU until alu_done or until
//   TIMEOUT cycles pass. It captures the result and flags, owns the
//   architectural HI/LO registers, and presents GPR writebacks over a
//   valid/ready port.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | issue_ready high; MTHI/MTLO update HI/LO here with no WB beat
//   RUN   | alu_en high, operands held; waits for alu_done or timeout
//   WB    | wb_valid high, beat held until wb_ready is sampled high
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   issue_valid/ready/op/a/b/dest    operation issue handshake
//   alu_en/control/srcA/srcB         drive to the ALU
//   alu_result/hi/lo/overflow/zero   ALU results, used only in RUN
//   alu_done                         ALU completion, used only in RUN
//   wb_valid/ready/data/dest/we      GPR writeback handshake
//   wb_zero, wb_overflow             captured ALU flags
//   timeout_err                      one-cycle pulse when the ALU is abandoned
//   hi_reg, lo_reg                   architectural HI/LO
module alu_issue_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int DEST_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        issue_op,
  input  logic [31:0]       issue_a,
  input  logic [31:0]       issue_b,
  input  logic [DEST_W-1:0] issue_dest,
  output logic              alu_en,
  output logic [3:0]        alu_control,
  output logic [31:0]       alu_srcA,
  output logic [31:0]       alu_srcB,
  input  logic [31:0]       alu_result,
  input  logic [31:0]       alu_hi,
  input  logic [31:0]       alu_lo,
  input  logic              alu_overflow,
  input  logic              alu_zero,
  input  logic              alu_done,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [31:0]       wb_data,
  output logic [DEST_W-1:0] wb_dest,
  output logic              wb_we,
  output logic              wb_zero,
  output logic              wb_overflow,
  output logic              timeout_err,
  output logic [31:0]       hi_reg,
  output logic [31:0]       lo_reg
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFHI = 4'b1010;
  localparam logic [3:0] OP_MFLO = 4'b1011;
  localparam logic [3:0] OP_MTHI = 4'b1100;
  localparam logic [3:0] OP_MTLO = 4'b1101;

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [DEST_W-1:0]  dest_q, dest_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               wb_we_q, wb_we_d;
  logic               wb_zero_q, wb_zero_d;
  logic               wb_ovf_q, wb_ovf_d;
  logic               timeout_q, timeout_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    dest_d    = dest_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    wb_we_d   = wb_we_q;
    wb_zero_d = wb_zero_q;
    wb_ovf_d  = wb_ovf_q;
    timeout_d = 1'b0;
    hi_d      = hi_q;
    lo_d      = lo_q;

    case (state_q)
      IDLE: begin
        if (issue_valid) begin
          if (issue_op <= OP_DIV) begin
            state_d = RUN;
            op_d    = issue_op;
            a_d     = issue_a;
            b_d     = issue_b;
            dest_d  = issue_dest;
            cnt_d   = '0;
          end else begin
            case (issue_op)
              OP_MFHI, OP_MFLO: begin
                state_d   = WB;
                dest_d    = issue_dest;
                wb_data_d = (issue_op == OP_MFHI) ? hi_q : lo_q;
                wb_we_d   = 1'b1;
                wb_zero_d = 1'b0;
                wb_ovf_d  = 1'b0;
              end
              OP_MTHI: hi_d = issue_a;
              OP_MTLO: lo_d = issue_a;
              // 1110 / 1111 are accepted and dropped.
              default: ;
            endcase
          end
        end
      end

      RUN: begin
        // A done in the last allowed cycle still wins over the timeout.
        if (alu_done) begin
          if (op_q == OP_MULT || op_q == OP_DIV) begin
            hi_d    = alu_hi;
            lo_d    = alu_lo;
            state_d = IDLE;
          end else begin
            state_d   = WB;
            wb_data_d = alu_result;
            wb_zero_d = alu_zero;
            wb_ovf_d  = alu_overflow;
            // Only signed add/sub trap on overflow; other ops still write.
            wb_we_d   = !((op_q == OP_ADD || op_q == OP_SUB) && alu_overflow);
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WB: begin
        if (wb_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      dest_q    <= '0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      wb_we_q   <= 1'b0;
      wb_zero_q <= 1'b0;
      wb_ovf_q  <= 1'b0;
      timeout_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      dest_q    <= dest_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      wb_we_q   <= wb_we_d;
      wb_zero_q <= wb_zero_d;
      wb_ovf_q  <= wb_ovf_d;
      timeout_q <= timeout_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign issue_ready = (state_q == IDLE);
  assign alu_en      = (state_q == RUN);
  assign alu_control = op_q;
  assign alu_srcA    = a_q;
  assign alu_srcB    = b_q;
  assign wb_valid    = (state_q == WB);
  assign wb_data     = wb_data_q;
  assign wb_dest     = dest_q;
  assign wb_we       = wb_we_q;
  assign wb_zero     = wb_zero_q;
  assign wb_overflow = wb_ovf_q;
  assign timeout_err = timeout_q;
  assign hi_reg      = hi_q;
  assign lo_reg      = lo_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  issue_op;
  logic [31:0] issue_a;
  logic [31:0] issue_b;
  logic [4:0]  issue_dest;
  logic        alu_en;
  logic [3:0]  alu_control;
  logic [31:0] alu_srcA;
  logic [31:0] alu_srcB;
  logic [31:0] alu_result;
  logic [31:0] alu_hi;
  logic [31:0] alu_lo;
  logic        alu_overflow;
  logic        alu_zero;
  logic        alu_done;
  logic        wb_valid;
  logic        wb_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_dest;
  logic        wb_we;
  logic        wb_zero;
  logic        wb_overflow;
  logic        timeout_err;
  logic [31:0] hi_reg;
  logic [31:0] lo_reg;

  // Stub ALU: completes in its first enabled cycle when stub_done is set;
  // stray_done forces alu_done regardless of alu_en.
  logic stub_done;
  logic stray_done;
  assign alu_done = (alu_en && stub_done) || stray_done;

  int n_vec = 0;
  int n_err = 0;
  int en_cnt = 0;
  int en_base;

  always #5 clk = ~clk;

  always @(posedge clk) if (alu_en) en_cnt = en_cnt + 1;

  alu_issue_ctrl #(.TIMEOUT(8), .DEST_W(5)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op),
    .issue_a(issue_a), .issue_b(issue_b), .issue_dest(issue_dest),
    .alu_en(alu_en), .alu_control(alu_control), .alu_srcA(alu_srcA), .alu_srcB(alu_srcB),
    .alu_result(alu_result), .alu_hi(alu_hi), .alu_lo(alu_lo),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero), .alu_done(alu_done),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_dest(wb_dest),
    .wb_we(wb_we), .wb_zero(wb_zero), .wb_overflow(wb_overflow),
    .timeout_err(timeout_err), .hi_reg(hi_reg), .lo_reg(lo_reg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dest);
    issue_valid = 1'b1;
    issue_op    = op;
    issue_a     = a;
    issue_b     = b;
    issue_dest  = dest;
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic stub(input logic [31:0] res, input logic [31:0] hi, input logic [31:0] lo,
                      input logic ovf, input logic zero);
    alu_result   = res;
    alu_hi       = hi;
    alu_lo       = lo;
    alu_overflow = ovf;
    alu_zero     = zero;
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 1'b0; issue_op = '0; issue_a = '0; issue_b = '0; issue_dest = '0;
    wb_ready = 1'b0; stub_done = 1'b1; stray_done = 1'b0;
    stub(32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_alu_en", alu_en, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    chk("rst_hi", hi_reg, 0);
    chk("rst_lo", lo_reg, 0);

    // ADD 15+10 -> 25, minimum latency
    stub(32'd25, 32'd0, 32'd0, 1'b0, 1'b0);
    en_base = en_cnt;
    issue(4'd0, 32'd15, 32'd10, 5'd3);
    chk("add_run_en", alu_en, 1);
    chk("add_run_ctl", alu_control, 0);
    chk("add_run_srcA", alu_srcA, 15);
    chk("add_run_srcB", alu_srcB, 10);
    chk("add_run_ready", issue_ready, 0);
    chk("add_run_wbv", wb_valid, 0);
    tick();
    chk("add_wbv_k2", wb_valid, 1);
    chk("add_data", wb_data, 25);
    chk("add_dest", wb_dest, 3);
    chk("add_we", wb_we, 1);
    chk("add_zero", wb_zero, 0);
    chk("add_en_off", alu_en, 0);
    chk("add_en_cycles", en_cnt - en_base, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("add_wb_drop", wb_valid, 0);
    chk("add_ready_back", issue_ready, 1);

    // SUB 10-10 with wb_ready held low for three cycles
    stub(32'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    issue(4'd1, 32'd10, 32'd10, 5'd4);
    chk("sub_run_ctl", alu_control, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("sub_hold_wbv", wb_valid, 1);
      chk("sub_hold_data", wb_data, 0);
      chk("sub_hold_zero", wb_zero, 1);
      chk("sub_hold_dest", wb_dest, 4);
      chk("sub_hold_ready", issue_ready, 0);
      tick();
    end
    chk("sub_still_wbv", wb_valid, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    chk("sub_wb_drop", wb_valid, 0);
    chk("sub_ready_back", issue_ready, 1);

    // MULT 131072*131072 -> HI=4, LO=0, no writeback
    stub(32'hFFFF_FFFF, 32'd4, 32'd0, 1'b0, 1'b0);
    issue(4'd8, 32'd131072, 32'd131072, 5'd0);
    chk("mult_run_ctl", alu_control, 8);
    tick();
    chk("mult_hi", hi_reg, 4);
    chk("mult_lo", lo_reg, 0);
    chk("mult_no_wb", wb_valid, 0);
    chk("mult_ready", issue_ready, 1);

    // Stray alu_done in IDLE must not touch HI/LO
    stub(32'd0, 32'd99, 32'd99, 1'b0, 1'b0);
    stray_done = 1'b1;
    tick();
    stray_done = 1'b0;
    chk("stray_hi", hi_reg, 4);
    chk("stray_wbv", wb_valid, 0);

    // MFHI dest 8
    en_base = en_cnt;
    issue(4'd10, 32'd0, 32'd0, 5'd8);
    chk("mfhi_wbv", wb_valid, 1);
    chk("mfhi_data", wb_data, 4);
    chk("mfhi_dest", wb_dest, 8);
    chk("mfhi_we", wb_we, 1);
    chk("mfhi_no_en", en_cnt - en_base, 0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // DIV 20/3 -> LO=6, HI=2, then MFLO
    stub(32'd0, 32'd2, 32'd6, 1'b0, 1'b0);
    issue(4'd9, 32'd20, 32'd3, 5'd0);
    tick();
    chk("div_hi", hi_reg, 2);
    chk("div_lo", lo_reg, 6);
    issue(4'd11, 32'd0, 32'd0, 5'd9);
    chk("mflo_data", wb_data, 6);
    chk("mflo_dest", wb_dest, 9);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // MTHI 0xDEADBEEF then MFHI, no ALU enable
    en_base = en_cnt;
    issue(4'd12, 32'hDEAD_BEEF, 32'd0, 5'd0);
    chk("mthi_hi", hi_reg, 32'hDEAD_BEEF);
    chk("mthi_lo_kept", lo_reg, 6);
    chk("mthi_no_wb", wb_valid, 0);
    chk("mthi_ready", issue_ready, 1);
    issue(4'd10, 32'd0, 32'd0, 5'd2);
    chk("mfhi2_data", wb_data, 32'hDEAD_BEEF);
    chk("mt_mf_no_en", en_cnt - en_base, 0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // Discarded opcode 1111
    issue(4'd15, 32'd5, 32'd5, 5'd1);
    chk("nop_ready", issue_ready, 1);
    chk("nop_no_wb", wb_valid, 0);
    chk("nop_no_en", alu_en, 0);

    // ADD overflow suppresses write
    stub(32'h8000_0000, 32'd0, 32'd0, 1'b1, 1'b0);
    issue(4'd0, 32'h7FFF_FFFF, 32'd1, 5'd5);
    tick();
    chk("addovf_data", wb_data, 32'h8000_0000);
    chk("addovf_flag", wb_overflow, 1);
    chk("addovf_we", wb_we, 0);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // SLT with overflow flag still writes
    stub(32'd1, 32'd0, 32'd0, 1'b1, 1'b0);
    issue(4'd5, 32'd1, 32'd2, 5'd6);
    tick();
    chk("slt_data", wb_data, 1);
    chk("slt_flag", wb_overflow, 1);
    chk("slt_we", wb_we, 1);
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;

    // Timeout: TIMEOUT=8, ALU never completes
    stub_done = 1'b0;
    stub(32'd0, 32'd77, 32'd77, 1'b0, 1'b0);
    en_base = en_cnt;
    issue(4'd2, 32'd3, 32'd4, 5'd7);
    for (int i = 0; i < 8; i++) begin
      chk("to_en_high", alu_en, 1);
      chk("to_no_err", timeout_err, 0);
      tick();
    end
    chk("to_en_low", alu_en, 0);
    chk("to_err_pulse", timeout_err, 1);
    chk("to_ready", issue_ready, 1);
    chk("to_no_wb", wb_valid, 0);
    chk("to_en_cycles", en_cnt - en_base, 8);
    chk("to_hi_kept", hi_reg, 32'hDEAD_BEEF);
    chk("to_lo_kept", lo_reg, 6);
    tick();
    chk("to_err_drop", timeout_err, 0);

    // Reset during RUN
    issue(4'd0, 32'd1, 32'd2, 5'd3);
    chk("rr_in_run", alu_en, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_en_low", alu_en, 0);
    chk("rr_hi", hi_reg, 0);
    chk("rr_lo", lo_reg, 0);
    chk("rr_no_wb", wb_valid, 0);
    stub_done = 1'b1;
    tick();
    chk("rr_ready", issue_ready, 1);
    chk("rr_no_wb2", wb_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
